multi_rate_recovery: RTL and testbench
======================================

# multi_rate_recovery

Parametrised, multi-channel rate recovery engine for the clock/data recovery path. Per channel it measures the spacing of one-cycle edge pulses from the upstream edge detector and locks onto the full rate in single, differential or quadrature mode. Locked channels report full and split half rates (high/low) and flag skew violations. Pausable channels hold their lock across idle gaps and relock downward when a faster rate appears.

## Interface
- CHANNELS, 4, independent recovery channels
- COUNTER_WIDTH, 16, interval counter width M (saturating)
- LOCK_COUNT, 4, consecutive in-tolerance intervals required to lock (≥2)
- sys_clk  in  1  system clock; the only clock
- sys_rst  in  1  synchronous, active-high reset
- enable  in  CHANNELS  per-channel run; low forces IDLE
- mode  in  2×CHANNELS  00 SINGLE, 01 DIF, 10 QUAD, 11 reserved (treated as SINGLE)
- pausable  in  CHANNELS  1 = pausable variant of mode
- edge_select  in  CHANNELS  SINGLE only: 0 rising_edge, 1 falling_edge qualifies
- odd_high  in  CHANNELS  odd full rate: 1 gives extra cycle to half_rate_high
- skew_tolerance  in  COUNTER_WIDTH×CHANNELS  allowed |M − ref|
- rising_edge, falling_edge, any_valid_edge  in  CHANNELS each  one-cycle edge pulses
- full_rate  out  (COUNTER_WIDTH+2)×CHANNELS  recovered full period, sys_clk cycles
- half_rate_high, half_rate_low  out  (COUNTER_WIDTH+1)×CHANNELS  split half periods
- locked  out  CHANNELS  rate outputs valid
- paused  out  CHANNELS  pausable channel in PAUSED
- violation  out  CHANNELS  one-cycle pulse on out-of-tolerance interval or counter saturation

## Operation
- Qualifying edge: SINGLE → rising_edge or falling_edge per edge_select; DIF, QUAD → any_valid_edge.
- Interval M = cycles between consecutive qualifying edges (edges at t0, t1 → M = t1 − t0). Counter saturates at 2^COUNTER_WIDTH − 1.
- Scaling: SINGLE full = M; DIF full = 2M; QUAD full = 4M. half_rate_high = full>>1, +1 if full odd and odd_high; half_rate_low = full − half_rate_high.
- mode, pausable, edge_select, odd_high latched on IDLE→ACQUIRE; ignored until enable drops. skew_tolerance is live.
- States per channel:
  - IDLE: outputs 0. enable=1 → ACQUIRE (unarmed).
  - ACQUIRE: first edge arms only. Each following M: if |M − ref| ≤ tol, run++; else ref ← M, run ← 1. run reaching LOCK_COUNT−1 matches → LOCKED; rate outputs computed from ref.
  - LOCKED, in tolerance: outputs held (ref not tracked).
  - LOCKED, pausable, 2M < ref: ref ← M, outputs updated, locked stays 1, no violation.
  - LOCKED, otherwise out of tolerance: violation pulse, locked ← 0, ACQUIRE with ref ← M, run ← 1 (armed).
  - LOCKED, pausable, counter exceeds 2·ref with no edge → PAUSED: outputs and locked held, paused=1.
  - PAUSED: next qualifying edge re-arms, → LOCKED; the gap interval is discarded.
  - Saturation in ACQUIRE/LOCKED, non-pausable: violation pulse, locked ← 0, ACQUIRE unarmed.
- enable low in any state → IDLE next cycle, all channel outputs 0.
- rising and falling in same cycle: one edge. Edge coincident with enable rise: ignored.

## Timing
- Reset: all outputs 0, all channels IDLE, counters 0.
- locked, rate outputs and violation register one cycle after the deciding edge pulse.
- PAUSED entered the cycle after counter passes 2·ref; paused clears the cycle after the resuming edge.
- Channels fully independent; no cross-channel arbitration.
- Reset mid-lock: next cycle identical to post-reset state.

## Configuration
- MULTI_RATE_RECOVERY_PAUSE_EN defined: pausable variants, PAUSED state, downward relock as above.
- Undefined: pausable input ignored (all channels continuous), no PAUSED logic, paused tied 0.

## Test plan
- SINGLE rising, edges every 10 cycles, tol 1, LOCK_COUNT 4 → locked on 5th edge +1 cycle; full 10, high 5, low 5.
- DIF, any_valid_edge every 7 cycles, odd_high=1 → full 14, high 7, low 7; odd_high with SINGLE M=9 → high 5, low 4.
- QUAD locked at M=5, tol 0, one interval of 6 → violation pulse, locked 0; three more at 6 → relock, full 24.
- Pausable DIF locked at M=8, 40-cycle gap → paused after cycle 17; edges resume at 8 → paused 0, locked held, no violation; then M=3 → full 6.
- Non-pausable, 16-bit counter, no edges after lock → violation at saturation, ACQUIRE; sys_rst mid-lock → all outputs 0 next cycle.

Source files
------------

// File: rtl/multi_rate_recovery.sv
// Multi-channel rate recovery: measures qualifying-edge spacing per channel and locks onto the rate.
// Define MULTI_RATE_RECOVERY_PAUSE_EN to build the pausable variants (PAUSED state, downward relock).

module multi_rate_recovery_lane #(
  parameter int W        = 16,
  parameter int LC       = 4,
  parameter bit PAUSE_EN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   cfg_mode,
  input  logic         cfg_pause,
  input  logic         cfg_esel,
  input  logic         cfg_oddh,
  input  logic [W-1:0] tol,
  input  logic         rise,
  input  logic         fall,
  input  logic         anye,
  output logic [W+1:0] full,
  output logic [W:0]   hi,
  output logic [W:0]   lo,
  output logic         lck,
  output logic         pau,
  output logic         vio
);
  localparam int RW = $clog2(LC + 1);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, PAUSED} state_t;

  state_t        st;
  logic [1:0]    mode_q;
  logic          pause_q, esel_q, oddh_q, armed;
  logic [W-1:0]  cnt, rf, cnt_inc, diff, rate_src;
  logic [RW-1:0] run;
  logic          qual, in_tol, sat, shrink, gap_long;
  logic [W+1:0]  full_n;
  logic [W:0]    hi_n, lo_n;

  always_comb begin
    qual     = (mode_q == 2'b01 || mode_q == 2'b10) ? anye : (esel_q ? fall : rise);
    sat      = &cnt;
    cnt_inc  = sat ? cnt : cnt + 1'b1;
    diff     = (cnt >= rf) ? cnt - rf : rf - cnt;
    in_tol   = diff <= tol;
    shrink   = PAUSE_EN && pause_q && ({cnt, 1'b0} < {1'b0, rf});
    gap_long = PAUSE_EN && pause_q && ({1'b0, cnt} > {rf, 1'b0});
    // Downward relock takes the new interval directly; acquisition locks on the reference.
    rate_src = (st == LOCKED) ? cnt : rf;
    case (mode_q)
      2'b01:   full_n = {1'b0, rate_src, 1'b0};
      2'b10:   full_n = {rate_src, 2'b00};
      default: full_n = {2'b00, rate_src};
    endcase
    hi_n = full_n[W+1:1] + {{W{1'b0}}, full_n[0] & oddh_q};
    lo_n = full_n[W:0] - hi_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;  mode_q <= '0; pause_q <= 1'b0; esel_q <= 1'b0; oddh_q <= 1'b0;
      armed <= 1'b0; cnt <= '0; rf <= '0; run <= '0;
      full <= '0; hi <= '0; lo <= '0; lck <= 1'b0; pau <= 1'b0; vio <= 1'b0;
    end else begin
      vio <= 1'b0;
      if (!en) begin
        st <= IDLE; armed <= 1'b0; cnt <= '0; run <= '0;
        full <= '0; hi <= '0; lo <= '0; lck <= 1'b0; pau <= 1'b0;
      end else begin
        case (st)
          IDLE: begin
            st <= ACQUIRE; mode_q <= cfg_mode; pause_q <= cfg_pause;
            esel_q <= cfg_esel; oddh_q <= cfg_oddh;
            armed <= 1'b0; cnt <= '0; run <= '0;
          end
          ACQUIRE: begin
            if (qual) begin
              cnt   <= W'(1);
              armed <= 1'b1;
              if (armed) begin
                if (run != '0 && in_tol) begin
                  if (int'(run) + 1 == LC) begin
                    st <= LOCKED; lck <= 1'b1; full <= full_n; hi <= hi_n; lo <= lo_n;
                  end else run <= run + 1'b1;
                end else begin
                  rf <= cnt; run <= RW'(1);
                end
              end
            end else if (armed && sat) begin
              vio <= 1'b1; armed <= 1'b0; run <= '0;
            end else cnt <= cnt_inc;
          end
          LOCKED: begin
            if (qual) begin
              cnt <= W'(1);
              if (!in_tol) begin
                if (shrink) begin
                  rf <= cnt; full <= full_n; hi <= hi_n; lo <= lo_n;
                end else begin
                  vio <= 1'b1; lck <= 1'b0; full <= '0; hi <= '0; lo <= '0;
                  st <= ACQUIRE; rf <= cnt; run <= RW'(1);
                end
              end
            end else if (gap_long) begin
              st <= PAUSED; pau <= 1'b1; cnt <= cnt_inc;
            end else if (sat) begin
              vio <= 1'b1; lck <= 1'b0; full <= '0; hi <= '0; lo <= '0;
              st <= ACQUIRE; armed <= 1'b0; run <= '0;
            end else cnt <= cnt_inc;
          end
          PAUSED: begin
            // The gap interval is thrown away; counting restarts at the resuming edge.
            if (qual) begin
              st <= LOCKED; pau <= 1'b0; cnt <= W'(1);
            end else cnt <= cnt_inc;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

module multi_rate_recovery #(
  parameter int CHANNELS      = 4,
  parameter int COUNTER_WIDTH = 16,
  parameter int LOCK_COUNT    = 4
) (
  input  logic                                      sys_clk,
  input  logic                                      sys_rst,
  input  logic [CHANNELS-1:0]                       enable,
  input  logic [CHANNELS-1:0][1:0]                  mode,
  input  logic [CHANNELS-1:0]                       pausable,
  input  logic [CHANNELS-1:0]                       edge_select,
  input  logic [CHANNELS-1:0]                       odd_high,
  input  logic [CHANNELS-1:0][COUNTER_WIDTH-1:0]    skew_tolerance,
  input  logic [CHANNELS-1:0]                       rising_edge,
  input  logic [CHANNELS-1:0]                       falling_edge,
  input  logic [CHANNELS-1:0]                       any_valid_edge,
  output logic [CHANNELS-1:0][COUNTER_WIDTH+1:0]    full_rate,
  output logic [CHANNELS-1:0][COUNTER_WIDTH:0]      half_rate_high,
  output logic [CHANNELS-1:0][COUNTER_WIDTH:0]      half_rate_low,
  output logic [CHANNELS-1:0]                       locked,
  output logic [CHANNELS-1:0]                       paused,
  output logic [CHANNELS-1:0]                       violation
);
  logic [CHANNELS-1:0] pause_sel;

`ifdef MULTI_RATE_RECOVERY_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
  assign pause_sel = pausable;
`else
  localparam bit PAUSE_EN = 1'b0;
  logic unused_pausable;
  assign pause_sel       = '0;
  assign unused_pausable = ^pausable;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    multi_rate_recovery_lane #(
      .W(COUNTER_WIDTH), .LC(LOCK_COUNT), .PAUSE_EN(PAUSE_EN)
    ) u_lane (
      .clk(sys_clk), .rst(sys_rst), .en(enable[i]),
      .cfg_mode(mode[i]), .cfg_pause(pause_sel[i]), .cfg_esel(edge_select[i]),
      .cfg_oddh(odd_high[i]), .tol(skew_tolerance[i]),
      .rise(rising_edge[i]), .fall(falling_edge[i]), .anye(any_valid_edge[i]),
      .full(full_rate[i]), .hi(half_rate_high[i]), .lo(half_rate_low[i]),
      .lck(locked[i]), .pau(paused[i]), .vio(violation[i])
    );
  end
endmodule

// File: tb/tb_multi_rate_recovery.sv
// Bench for multi_rate_recovery: timestamp-based reference model checked every cycle, plus directed checks.
module tb_multi_rate_recovery;
  localparam int CH = 4, CW = 16, LC = 4, MAXC = 65535;
`ifdef MULTI_RATE_RECOVERY_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic sys_clk, sys_rst;
  logic [CH-1:0] enable, pausable, edge_select, odd_high, rising_edge, falling_edge, any_valid_edge;
  logic [CH-1:0][1:0] mode;
  logic [CH-1:0][CW-1:0] skew_tolerance;
  logic [CH-1:0][CW+1:0] full_rate;
  logic [CH-1:0][CW:0] half_rate_high, half_rate_low;
  logic [CH-1:0] locked, paused, violation;

  multi_rate_recovery #(.CHANNELS(CH), .COUNTER_WIDTH(CW), .LOCK_COUNT(LC)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .enable(enable), .mode(mode), .pausable(pausable),
    .edge_select(edge_select), .odd_high(odd_high), .skew_tolerance(skew_tolerance),
    .rising_edge(rising_edge), .falling_edge(falling_edge), .any_valid_edge(any_valid_edge),
    .full_rate(full_rate), .half_rate_high(half_rate_high), .half_rate_low(half_rate_low),
    .locked(locked), .paused(paused), .violation(violation));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0, failures = 0, now = 0;
  // reference model: state 0 idle, 1 acquire, 2 locked, 3 paused; last = time of last edge (-1 unarmed)
  int m_st[CH], m_last[CH], m_rf[CH], m_run[CH], m_mode[CH];
  bit m_pz[CH], m_es[CH], m_oh[CH];
  int e_full[CH], e_hi[CH], e_lo[CH];
  bit e_lck[CH], e_pau[CH], e_vio[CH];
  // edge generator
  bit gon[CH], pulsed[CH];
  int base[CH], per[CH], jit[CH], lastp[CH];

  task automatic chk(input string tag, input int c, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ch%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic timeout(input string tag, input int c);
    checks++; failures++;
    $error("FAIL %s ch%0d observed=timeout expected=event", tag, c);
  endtask

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic set_rate(input int c, input int m);
    int f;
    f = m * ((m_mode[c] == 1) ? 2 : (m_mode[c] == 2) ? 4 : 1);
    e_full[c] = f;
    e_hi[c]   = f / 2 + ((f % 2 == 1 && m_oh[c]) ? 1 : 0);
    e_lo[c]   = f - e_hi[c];
  endtask

  task automatic clr_out(input int c);
    e_full[c] = 0; e_hi[c] = 0; e_lo[c] = 0; e_lck[c] = 0; e_pau[c] = 0;
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit q;
      int gap, tol;
      e_vio[c] = 0;
      if (sys_rst) begin
        m_st[c] = 0; m_last[c] = -1; m_run[c] = 0; m_rf[c] = 0; clr_out(c);
      end else if (!enable[c]) begin
        m_st[c] = 0; m_last[c] = -1; m_run[c] = 0; clr_out(c);
      end else if (m_st[c] == 0) begin
        m_st[c] = 1; m_mode[c] = mode[c]; m_pz[c] = PEN & pausable[c];
        m_es[c] = edge_select[c]; m_oh[c] = odd_high[c]; m_last[c] = -1; m_run[c] = 0;
      end else begin
        q   = (m_mode[c] == 1 || m_mode[c] == 2) ? any_valid_edge[c]
                                                 : (m_es[c] ? falling_edge[c] : rising_edge[c]);
        gap = (m_last[c] < 0) ? 0 : ((now - m_last[c] > MAXC) ? MAXC : now - m_last[c]);
        tol = int'(skew_tolerance[c]);
        if (m_st[c] == 1) begin
          if (q) begin
            if (m_last[c] >= 0) begin
              if (m_run[c] > 0 && iabs(gap - m_rf[c]) <= tol) begin
                if (m_run[c] + 1 == LC) begin m_st[c] = 2; set_rate(c, m_rf[c]); e_lck[c] = 1; end
                else m_run[c]++;
              end else begin m_rf[c] = gap; m_run[c] = 1; end
            end
            m_last[c] = now;
          end else if (m_last[c] >= 0 && gap == MAXC) begin
            e_vio[c] = 1; m_last[c] = -1; m_run[c] = 0;
          end
        end else if (m_st[c] == 2) begin
          if (q) begin
            m_last[c] = now;
            if (iabs(gap - m_rf[c]) > tol) begin
              if (m_pz[c] && 2 * gap < m_rf[c]) begin m_rf[c] = gap; set_rate(c, gap); end
              else begin e_vio[c] = 1; clr_out(c); m_st[c] = 1; m_rf[c] = gap; m_run[c] = 1; end
            end
          end else if (m_pz[c] && gap > 2 * m_rf[c]) begin
            m_st[c] = 3; e_pau[c] = 1;
          end else if (gap == MAXC) begin
            e_vio[c] = 1; clr_out(c); m_st[c] = 1; m_last[c] = -1; m_run[c] = 0;
          end
        end else if (q) begin
          m_st[c] = 2; e_pau[c] = 0; m_last[c] = now;
        end
      end
    end
  endtask

  task automatic tick();
    for (int c = 0; c < CH; c++) begin
      bit fire, dif;
      rising_edge[c] = 0; falling_edge[c] = 0; any_valid_edge[c] = 0; pulsed[c] = 0;
      if (gon[c]) begin
        fire = (now - lastp[c] >= per[c]);
        dif  = (mode[c] == 2'b01 || mode[c] == 2'b10);
        if (fire) begin
          pulsed[c] = 1; lastp[c] = now;
          per[c] = base[c] + ((jit[c] > 0) ? int'($urandom_range(0, 2 * jit[c])) - jit[c] : 0);
          if (per[c] < 2) per[c] = 2;
        end
        if (dif) begin
          any_valid_edge[c] = fire;
          rising_edge[c] = ($urandom_range(0, 5) == 0); falling_edge[c] = ($urandom_range(0, 5) == 0);
        end else if (edge_select[c]) begin
          falling_edge[c] = fire;
          rising_edge[c] = ($urandom_range(0, 5) == 0); any_valid_edge[c] = ($urandom_range(0, 5) == 0);
        end else begin
          rising_edge[c] = fire;
          falling_edge[c] = ($urandom_range(0, 5) == 0); any_valid_edge[c] = ($urandom_range(0, 5) == 0);
        end
      end
    end
    model_step();
    @(posedge sys_clk);
    #1;
    now++;
    for (int c = 0; c < CH; c++) begin
      chk("full", c, full_rate[c], e_full[c]);
      chk("high", c, half_rate_high[c], e_hi[c]);
      chk("low", c, half_rate_low[c], e_lo[c]);
      chk("locked", c, locked[c], e_lck[c]);
      chk("paused", c, paused[c], e_pau[c]);
      chk("violation", c, violation[c], e_vio[c]);
    end
  endtask

  task automatic cfg(input int c, input int md, input bit pz, input bit es, input bit oh,
                     input int tol, input int p, input int j);
    mode[c] = md[1:0]; pausable[c] = pz; edge_select[c] = es; odd_high[c] = oh;
    skew_tolerance[c] = tol[CW-1:0]; base[c] = p; per[c] = p; jit[c] = j;
  endtask

  task automatic go(input int c);
    enable[c] = 1; gon[c] = 1; lastp[c] = now;
  endtask

  task automatic halt(input int c);
    enable[c] = 0; gon[c] = 0;
  endtask

  task automatic setp(input int c, input int p);
    base[c] = p; per[c] = p;
  endtask

  task automatic wait_pulse(input int c);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin tick(); got = pulsed[c]; end
    if (!got) timeout("edge_wait", c);
  endtask

  initial begin
    int t0;
    sys_rst = 1; enable = '0; pausable = '0; edge_select = '0; odd_high = '0; mode = '0;
    skew_tolerance = '0; rising_edge = '0; falling_edge = '0; any_valid_edge = '0;
    for (int c = 0; c < CH; c++) begin
      gon[c] = 0; base[c] = 10; per[c] = 10; jit[c] = 0; lastp[c] = 0;
    end
    tick(); tick();
    for (int c = 0; c < CH; c++) begin
      chk("rst_locked", c, locked[c], 0); chk("rst_full", c, full_rate[c], 0);
    end
    sys_rst = 0;

    // basic locking in each mode
    cfg(0, 0, 0, 0, 0, 1, 10, 0); cfg(1, 1, 0, 0, 1, 1, 7, 0);
    cfg(2, 0, 0, 1, 1, 0, 9, 0);  cfg(3, 2, 0, 0, 0, 0, 5, 0);
    for (int c = 0; c < CH; c++) go(c);
    repeat (4) wait_pulse(0);
    chk("lock_early", 0, locked[0], 0);
    wait_pulse(0);
    chk("lock_single", 0, locked[0], 1);
    chk("single_full", 0, full_rate[0], 10);
    chk("single_high", 0, half_rate_high[0], 5);
    chk("single_low", 0, half_rate_low[0], 5);
    repeat (30) tick();
    chk("dif_full", 1, full_rate[1], 14);
    chk("dif_high", 1, half_rate_high[1], 7);
    chk("dif_low", 1, half_rate_low[1], 7);
    chk("odd_high", 2, half_rate_high[2], 5);
    chk("odd_low", 2, half_rate_low[2], 4);
    chk("quad_full", 3, full_rate[3], 20);

    // QUAD: one out-of-tolerance interval, then relock at the new rate
    setp(3, 6);
    wait_pulse(3);
    chk("quad_vio", 3, violation[3], 1);
    chk("quad_unlock", 3, locked[3], 0);
    repeat (3) wait_pulse(3);
    chk("quad_relock", 3, locked[3], 1);
    chk("quad_full24", 3, full_rate[3], 24);

    halt(0); tick();
    chk("dis_locked", 0, locked[0], 0);
    chk("dis_full", 0, full_rate[0], 0);

`ifdef MULTI_RATE_RECOVERY_PAUSE_EN
    halt(1); tick();
    cfg(1, 1, 1, 0, 0, 0, 8, 0); go(1);
    repeat (5) wait_pulse(1);
    chk("pz_locked", 1, locked[1], 1);
    setp(1, 40);
    repeat (16) tick();
    chk("pz_not_yet", 1, paused[1], 0);
    tick();
    chk("pz_paused", 1, paused[1], 1);
    chk("pz_hold", 1, locked[1], 1);
    wait_pulse(1);
    setp(1, 8);
    chk("pz_resume", 1, paused[1], 0);
    chk("pz_res_lock", 1, locked[1], 1);
    chk("pz_res_vio", 1, violation[1], 0);
    repeat (2) wait_pulse(1);
    chk("pz_full16", 1, full_rate[1], 16);
    setp(1, 3);
    wait_pulse(1);
    chk("pz_down_full", 1, full_rate[1], 6);
    chk("pz_down_lock", 1, locked[1], 1);
    chk("pz_down_vio", 1, violation[1], 0);
`endif

    // randomized configurations with jitter
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < CH; c++) halt(c);
      tick();
      for (int c = 0; c < CH; c++) begin
        cfg(c, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), int'($urandom_range(3, 20)),
            int'($urandom_range(0, 2)));
        go(c);
      end
      repeat (400) tick();
    end

    // counter saturation on a non-pausable locked channel
    halt(2); tick();
    cfg(2, 0, 0, 0, 0, 0, 9, 0); go(2);
    repeat (5) wait_pulse(2);
    chk("sat_pre_lock", 2, locked[2], 1);
    gon[2] = 0; t0 = lastp[2];
    for (int k = 0; k < 70000 && !violation[2]; k++) tick();
    if (!violation[2]) timeout("sat_wait", 2);
    chk("sat_delay", 2, now - 1 - t0, MAXC);
    chk("sat_unlock", 2, locked[2], 0);

    // reset while locked
    halt(0); tick();
    cfg(0, 0, 0, 0, 0, 0, 6, 0); go(0);
    repeat (5) wait_pulse(0);
    chk("mid_lock", 0, locked[0], 1);
    sys_rst = 1; tick();
    for (int c = 0; c < CH; c++) begin
      chk("mrst_locked", c, locked[c], 0); chk("mrst_full", c, full_rate[c], 0);
      chk("mrst_paused", c, paused[c], 0);
    end
    sys_rst = 0;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
